// File: rtl/alu_instr_sequencer.sv
// Hardwired control unit for the bus-based datapath: fetch (T0-T2) and execute
// (T3-T6) of register-register ALU instructions, with halt/resume control.
module alu_instr_sequencer #(
  parameter int OPW = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        start,
  input  logic        stop,
  output logic        pc_out,
  output logic        mar_in,
  output logic        inc_pc,
  output logic        pc_in,
  output logic        read,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        z_low_out,
  output logic        z_high_out,
  output logic        hi_in,
  output logic        lo_in,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        instr_done
);

  typedef enum logic [3:0] {
    S_INIT, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    K_ALU3, K_MULDIV, K_UNARY, K_NOP, K_HALT
  } kind_t;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0011,
    ALU_SHR = 4'b0100, ALU_SHL = 4'b0101, ALU_ROR = 4'b0110, ALU_ROL = 4'b0111,
    ALU_MUL = 4'b1000, ALU_DIV = 4'b1001, ALU_NEG = 4'b1010, ALU_NOT = 4'b1011
  } alu_t;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  state_t         state;
  kind_t          kind;
  alu_t           alu_code;
  logic [OPW-1:0] opcode;
  state_t         boundary;
  logic           unused_ir;

  assign opcode = ir[31 -: OPW];
  // Register fields are consumed by the external select-and-encode logic.
  assign unused_ir = ^ir[31-OPW:0];

  // Instruction class and ALU function; unknown opcodes (and nop) fall to K_NOP.
  always_comb begin
    kind     = K_NOP;
    alu_code = ALU_AND;
    case (opcode)
      OP_ADD:  begin kind = K_ALU3;   alu_code = ALU_ADD; end
      OP_SUB:  begin kind = K_ALU3;   alu_code = ALU_SUB; end
      OP_SHR:  begin kind = K_ALU3;   alu_code = ALU_SHR; end
      OP_SHL:  begin kind = K_ALU3;   alu_code = ALU_SHL; end
      OP_ROR:  begin kind = K_ALU3;   alu_code = ALU_ROR; end
      OP_ROL:  begin kind = K_ALU3;   alu_code = ALU_ROL; end
      OP_AND:  begin kind = K_ALU3;   alu_code = ALU_AND; end
      OP_OR:   begin kind = K_ALU3;   alu_code = ALU_OR;  end
      OP_MUL:  begin kind = K_MULDIV; alu_code = ALU_MUL; end
      OP_DIV:  begin kind = K_MULDIV; alu_code = ALU_DIV; end
      OP_NEG:  begin kind = K_UNARY;  alu_code = ALU_NEG; end
      OP_NOT:  begin kind = K_UNARY;  alu_code = ALU_NOT; end
      OP_HALT: kind = K_HALT;
      default: kind = K_NOP;
    endcase
  end

  assign boundary = stop ? S_HALTED : S_T0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      case (state)
        S_INIT:   state <= boundary;
        S_T0:     state <= S_T1;
        S_T1:     state <= mem_ready ? S_T2 : S_T1;
        S_T2:     state <= S_T3;
        S_T3: begin
          case (kind)
            K_HALT:  state <= S_HALTED;
            K_NOP:   state <= boundary;
            default: state <= S_T4;
          endcase
        end
        S_T4:     state <= (kind == K_ALU3 || kind == K_MULDIV) ? S_T5 : boundary;
        S_T5:     state <= (kind == K_MULDIV) ? S_T6 : boundary;
        S_T6:     state <= boundary;
        S_HALTED: state <= (start && !stop) ? S_T0 : S_HALTED;
        default:  state <= S_INIT;
      endcase
    end
  end

  // Moore decode of state and opcode; everything is forced quiet while reset is high.
  always_comb begin
    pc_out = 1'b0; mar_in = 1'b0; inc_pc = 1'b0; pc_in = 1'b0; read = 1'b0;
    mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0;
    z_low_out = 1'b0; z_high_out = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0;
    alu_op = ALU_AND; run = 1'b0; instr_done = 1'b0;
    if (!reset) begin
      case (state)
        S_T0: begin
          run = 1'b1; pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1;
          z_in = 1'b1; alu_op = ALU_ADD;
        end
        S_T1: begin
          run = 1'b1; z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
        end
        S_T2: begin
          run = 1'b1; mdr_out = 1'b1; ir_in = 1'b1;
        end
        S_T3: begin
          run = 1'b1;
          case (kind)
            K_ALU3:   begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
            K_MULDIV: begin gra = 1'b1; r_out = 1'b1; y_in = 1'b1; end
            K_UNARY: begin
              grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_code;
            end
            default:  instr_done = 1'b1;
          endcase
        end
        S_T4: begin
          run = 1'b1;
          case (kind)
            K_ALU3: begin
              grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_code;
            end
            K_MULDIV: begin
              grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_code;
            end
            default: begin
              z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; instr_done = 1'b1;
            end
          endcase
        end
        S_T5: begin
          run = 1'b1;
          z_low_out = 1'b1;
          if (kind == K_MULDIV) begin
            lo_in = 1'b1;
          end else begin
            gra = 1'b1; r_in = 1'b1; instr_done = 1'b1;
          end
        end
        S_T6: begin
          run = 1'b1; z_high_out = 1'b1; hi_in = 1'b1; instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboarded bench: stimulus pushes the expected control word for every cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b0, start = 1'b0, stop = 1'b0;
  logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in;
  logic z_low_out, z_high_out, hi_in, lo_in, gra, grb, grc, r_in, r_out, run, instr_done;
  logic [3:0] alu_op;

  alu_instr_sequencer #(.OPW(5)) dut (
    .clk(clk), .reset(reset), .ir(ir), .mem_ready(mem_ready), .start(start), .stop(stop),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in), .read(read),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .z_low_out(z_low_out), .z_high_out(z_high_out), .hi_in(hi_in), .lo_in(lo_in),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .alu_op(alu_op),
    .run(run), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  localparam logic [24:0] ONE = 25'd1;
  localparam logic [24:0] PC_OUT = ONE << 24, MAR_IN = ONE << 23, INC_PC = ONE << 22;
  localparam logic [24:0] PC_IN = ONE << 21, READ = ONE << 20, MDR_IN = ONE << 19;
  localparam logic [24:0] MDR_OUT = ONE << 18, IR_IN = ONE << 17, Y_IN = ONE << 16;
  localparam logic [24:0] Z_IN = ONE << 15, Z_LOW = ONE << 14, Z_HIGH = ONE << 13;
  localparam logic [24:0] HI_IN = ONE << 12, LO_IN = ONE << 11, GRA = ONE << 10;
  localparam logic [24:0] GRB = ONE << 9, GRC = ONE << 8, R_IN = ONE << 7, R_OUT = ONE << 6;
  localparam logic [24:0] RUN = ONE << 1, DONE = ONE;

  localparam int K_ALU3 = 0, K_MULDIV = 1, K_UNARY = 2, K_NOP = 3, K_HALT = 4;

  logic [4:0] valid_ops [12] = '{5'b00011, 5'b00100, 5'b00101, 5'b00111, 5'b01000, 5'b01001,
                                 5'b01010, 5'b01011, 5'b01110, 5'b01111, 5'b10000, 5'b10001};

  logic [24:0] exp_q[$];
  int compared = 0, mismatched = 0;
  logic [24:0] actual;

  assign actual = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in,
                   z_low_out, z_high_out, hi_in, lo_in, gra, grb, grc, r_in, r_out,
                   alu_op, run, instr_done};

  function automatic logic [24:0] alu(input logic [3:0] a);
    return {19'd0, a, 2'd0};
  endfunction

  // Reference opcode table: instruction class and ALU function.
  function automatic void op_info(input logic [4:0] op, output int kind, output logic [3:0] a);
    a = 4'b0000;
    kind = K_ALU3;
    case (op)
      5'b00011: a = 4'b0010;
      5'b00100: a = 4'b0011;
      5'b00101: a = 4'b0100;
      5'b00111: a = 4'b0101;
      5'b01000: a = 4'b0110;
      5'b01001: a = 4'b0111;
      5'b01010: a = 4'b0000;
      5'b01011: a = 4'b0001;
      5'b01110: begin kind = K_MULDIV; a = 4'b1000; end
      5'b01111: begin kind = K_MULDIV; a = 4'b1001; end
      5'b10000: begin kind = K_UNARY;  a = 4'b1010; end
      5'b10001: begin kind = K_UNARY;  a = 4'b1011; end
      5'b11011: kind = K_HALT;
      default:  kind = K_NOP;
    endcase
  endfunction

  task automatic step(input bit rs, input bit mr, input bit st, input bit sa, input logic [24:0] w);
    @(posedge clk);
    #1;
    reset = rs; mem_ready = mr; stop = st; start = sa;
    exp_q.push_back(w);
  endtask

  task automatic halted_seq();
    int n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) step(0, 1'($urandom), 1'($urandom), 0, '0);
    step(0, 1'($urandom), 1, 1, '0);
    step(0, 1'($urandom), 0, 1, '0);
  endtask

  // abort_at: index of the execute state where reset hits (-1 = none);
  // stop_end: stop at the final boundary, or at INIT after an abort.
  task automatic run_instr(input logic [31:0] word, input int stalls, input bit stop_end,
                           input int abort_at);
    logic [24:0] ex[$];
    logic [4:0]  op;
    logic [3:0]  a;
    int kind;
    op = word[31:27];
    op_info(op, kind, a);
    case (kind)
      K_ALU3: begin
        ex.push_back(GRB | R_OUT | Y_IN | RUN);
        ex.push_back(GRC | R_OUT | Z_IN | alu(a) | RUN);
        ex.push_back(Z_LOW | GRA | R_IN | DONE | RUN);
      end
      K_MULDIV: begin
        ex.push_back(GRA | R_OUT | Y_IN | RUN);
        ex.push_back(GRB | R_OUT | Z_IN | alu(a) | RUN);
        ex.push_back(Z_LOW | LO_IN | RUN);
        ex.push_back(Z_HIGH | HI_IN | DONE | RUN);
      end
      K_UNARY: begin
        ex.push_back(GRB | R_OUT | Z_IN | alu(a) | RUN);
        ex.push_back(Z_LOW | GRA | R_IN | DONE | RUN);
      end
      default: ex.push_back(DONE | RUN);
    endcase
    step(0, 1'($urandom), 1'($urandom), 0, PC_OUT | MAR_IN | INC_PC | Z_IN | alu(4'b0010) | RUN);
    ir = word;
    for (int i = 0; i <= stalls; i++)
      step(0, i == stalls, 1'($urandom), 0, Z_LOW | PC_IN | READ | MDR_IN | RUN);
    step(0, 1'($urandom), 1'($urandom), 0, MDR_OUT | IR_IN | RUN);
    for (int i = 0; i < ex.size(); i++) begin
      if (i == abort_at) begin
        step(1, 1'($urandom), 0, 0, '0);
        step(1, 1'($urandom), 0, 0, '0);
        step(0, 1'($urandom), stop_end, 0, '0);
        if (stop_end) halted_seq();
        return;
      end
      step(0, 1'($urandom), (i == ex.size() - 1) ? stop_end : 1'($urandom), 0, ex[i]);
    end
    if (kind == K_HALT || stop_end) halted_seq();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [24:0] e;
      e = exp_q.pop_front();
      compared++;
      if (actual !== e) begin
        mismatched++;
        $display("FAIL ctrl_word t=%0t actual=%b required=%b", $time, actual, e);
      end
    end
  end

  initial begin
    logic [31:0] w;
    step(1, 1, 0, 0, '0);
    step(1, 1, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    run_instr(32'h7920_0000, 0, 0, -1);
    run_instr(32'h1A92_0000, 0, 0, -1);
    run_instr(32'h81B0_0000, 0, 0, -1);
    run_instr(32'h1A92_0000, 3, 0, -1);
    run_instr(32'hD800_0000, 0, 0, -1);
    run_instr(32'h1A92_0000, 1, 1, -1);
    run_instr(32'h1A92_0000, 0, 0, 1);
    run_instr(32'h7120_0000, 0, 1, 3);
    run_instr(32'hD000_0000, 2, 0, -1);
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      if ($urandom_range(0, 2) != 0) w[31:27] = valid_ops[$urandom_range(0, 11)];
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
